// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode feeding the execute stage.
// Owns load-use detection: one bubble per load-use pair, fetch held meanwhile.

`ifndef ALU_WIDTH
`define ALU_WIDTH       14
`define ALU_ADD         0
`define ALU_SUB         1
`define ALU_SLL         2
`define ALU_SLT         3
`define ALU_SLTU        4
`define ALU_XOR         5
`define ALU_SRL         6
`define ALU_SRA         7
`define ALU_OR          8
`define ALU_AND         9
`define ALU_EQ          10
`define ALU_NEQ         11
`define ALU_GE          12
`define ALU_GEU         13
`endif

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH    11
`define RTYPE           0
`define ITYPE           1
`define LOAD_WORD       2
`define STORE_WORD      3
`define BRANCH          4
`define JAL             5
`define JALR            6
`define LUI             7
`define AUIPC           8
`define SYSTEM          9
`define FENCE           10
`endif

`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`define ILLEGAL         0
`define ECALL           1
`define EBREAK          2
`define MRET            3
`endif

module decode_stage #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                        d_clk,
    input  logic                        d_rst,
    input  logic [31:0]                 d_i_inst,
    input  logic [PC_WIDTH-1:0]         d_i_pc,
    input  logic                        d_i_valid,
    input  logic                        d_i_stall,
    input  logic                        d_i_flush,
    output logic                        d_o_stall,
    output logic                        d_o_valid,
    output logic [PC_WIDTH-1:0]         d_o_pc,
    output logic [AWIDTH-1:0]           d_o_addr_rs1,
    output logic [AWIDTH-1:0]           d_o_addr_rs2,
    output logic [AWIDTH-1:0]           d_o_addr_rd,
    output logic [2:0]                  d_o_funct3,
    output logic [DWIDTH-1:0]           d_o_imm,
    output logic [`ALU_WIDTH-1:0]       d_o_alu,
    output logic [`OPCODE_WIDTH-1:0]    d_o_opcode,
    output logic [`EXCEPTION_WIDTH-1:0] d_o_exception
);

    logic [2:0]                  funct3;
    logic [6:0]                  funct7;
    logic [AWIDTH-1:0]           rs1, rs2, rd;
    logic [31:0]                 imm32;
    logic [`ALU_WIDTH-1:0]       alu;
    logic [`OPCODE_WIDTH-1:0]    opc;
    logic [`EXCEPTION_WIDTH-1:0] exc;
    logic                        use_rs1, use_rs2, hazard;
    logic                        bubble, capture;

    assign funct3 = d_i_inst[14:12];
    assign funct7 = d_i_inst[31:25];
    assign rs1    = AWIDTH'(d_i_inst[19:15]);
    assign rs2    = AWIDTH'(d_i_inst[24:20]);
    assign rd     = AWIDTH'(d_i_inst[11:7]);

    // Shared RTYPE/ITYPE ALU select; SUB only exists for register operands.
    function automatic logic [`ALU_WIDTH-1:0] arith(input logic [2:0] f3,
                                                    input logic b30,
                                                    input logic is_r);
        logic [`ALU_WIDTH-1:0] a;
        a = '0;
        case (f3)
            3'b000:  a[(b30 && is_r) ? `ALU_SUB : `ALU_ADD] = 1'b1;
            3'b001:  a[`ALU_SLL]  = 1'b1;
            3'b010:  a[`ALU_SLT]  = 1'b1;
            3'b011:  a[`ALU_SLTU] = 1'b1;
            3'b100:  a[`ALU_XOR]  = 1'b1;
            3'b101:  a[b30 ? `ALU_SRA : `ALU_SRL] = 1'b1;
            3'b110:  a[`ALU_OR]   = 1'b1;
            default: a[`ALU_AND]  = 1'b1;
        endcase
        return a;
    endfunction

    // Combinational decode of the incoming instruction.
    always_comb begin
        opc   = '0;
        alu   = '0;
        exc   = '0;
        imm32 = '0;
        case (d_i_inst[6:0])
            7'b0110011: begin
                opc[`RTYPE] = 1'b1;
                alu = arith(funct3, d_i_inst[30], 1'b1);
                if (!(funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
                    exc[`ILLEGAL] = 1'b1;
            end
            7'b0010011: begin
                opc[`ITYPE] = 1'b1;
                alu   = arith(funct3, d_i_inst[30], 1'b0);
                imm32 = {{20{d_i_inst[31]}}, d_i_inst[31:20]};
                if (funct3 == 3'b001 && funct7 != 7'b0000000)
                    exc[`ILLEGAL] = 1'b1;
                if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    exc[`ILLEGAL] = 1'b1;
            end
            7'b0000011: begin
                opc[`LOAD_WORD] = 1'b1;
                alu[`ALU_ADD]   = 1'b1;
                imm32 = {{20{d_i_inst[31]}}, d_i_inst[31:20]};
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
                    exc[`ILLEGAL] = 1'b1;
            end
            7'b0100011: begin
                opc[`STORE_WORD] = 1'b1;
                alu[`ALU_ADD]    = 1'b1;
                imm32 = {{20{d_i_inst[31]}}, d_i_inst[31:25], d_i_inst[11:7]};
                if (funct3 >= 3'b011)
                    exc[`ILLEGAL] = 1'b1;
            end
            7'b1100011: begin
                opc[`BRANCH] = 1'b1;
                imm32 = {{20{d_i_inst[31]}}, d_i_inst[7], d_i_inst[30:25],
                         d_i_inst[11:8], 1'b0};
                case (funct3)
                    3'b000:  alu[`ALU_EQ]   = 1'b1;
                    3'b001:  alu[`ALU_NEQ]  = 1'b1;
                    3'b100:  alu[`ALU_SLT]  = 1'b1;
                    3'b101:  alu[`ALU_GE]   = 1'b1;
                    3'b110:  alu[`ALU_SLTU] = 1'b1;
                    3'b111:  alu[`ALU_GEU]  = 1'b1;
                    default: exc[`ILLEGAL]  = 1'b1;
                endcase
            end
            7'b1101111: begin
                opc[`JAL]     = 1'b1;
                alu[`ALU_ADD] = 1'b1;
                imm32 = {{12{d_i_inst[31]}}, d_i_inst[19:12], d_i_inst[20],
                         d_i_inst[30:21], 1'b0};
            end
            7'b1100111: begin
                opc[`JALR]    = 1'b1;
                alu[`ALU_ADD] = 1'b1;
                imm32 = {{20{d_i_inst[31]}}, d_i_inst[31:20]};
                if (funct3 != 3'b000)
                    exc[`ILLEGAL] = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                opc[d_i_inst[5] ? `LUI : `AUIPC] = 1'b1;
                alu[`ALU_ADD] = 1'b1;
                imm32 = {d_i_inst[31:12], 12'b0};
            end
            7'b1110011: begin
                opc[`SYSTEM] = 1'b1;
                case (d_i_inst)
                    32'h0000_0073: exc[`ECALL]   = 1'b1;
                    32'h0010_0073: exc[`EBREAK]  = 1'b1;
                    32'h3020_0073: exc[`MRET]    = 1'b1;
                    default:       exc[`ILLEGAL] = 1'b1;
                endcase
            end
            7'b0001111: opc[`FENCE] = 1'b1;
            default:    exc[`ILLEGAL] = 1'b1;
        endcase
    end

    // Load-use detection against the load currently sitting in the register.
    always_comb begin
        use_rs1 = (|opc) & ~(opc[`LUI] | opc[`AUIPC] | opc[`JAL]);
        use_rs2 = opc[`RTYPE] | opc[`STORE_WORD] | opc[`BRANCH];
        hazard  = d_o_valid & d_o_opcode[`LOAD_WORD] & (d_o_addr_rd != '0) & d_i_valid &
                  ((use_rs1 & (rs1 == d_o_addr_rd)) | (use_rs2 & (rs2 == d_o_addr_rd)));
    end

    assign d_o_stall = d_rst & (d_i_stall | (hazard & ~d_i_flush));
    assign bubble    = d_i_flush | (~d_i_stall & (hazard | ~d_i_valid));
    assign capture   = ~d_i_flush & ~d_i_stall & ~hazard & d_i_valid;

    // Pipeline register: flush > stall > hazard bubble > capture.
    always_ff @(posedge d_clk or negedge d_rst) begin
        if (!d_rst || bubble) begin
            d_o_valid     <= 1'b0;
            d_o_pc        <= '0;
            d_o_addr_rs1  <= '0;
            d_o_addr_rs2  <= '0;
            d_o_addr_rd   <= '0;
            d_o_funct3    <= '0;
            d_o_imm       <= '0;
            d_o_alu       <= '0;
            d_o_opcode    <= '0;
            d_o_exception <= '0;
        end else if (capture) begin
            d_o_valid     <= 1'b1;
            d_o_pc        <= d_i_pc;
            d_o_addr_rs1  <= rs1;
            d_o_addr_rs2  <= rs2;
            d_o_addr_rd   <= rd;
            d_o_funct3    <= funct3;
            d_o_imm       <= DWIDTH'($signed(imm32));
            d_o_alu       <= alu;
            d_o_opcode    <= opc;
            d_o_exception <= exc;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table plus hand sequences, scoreboard-checked.
module tb_decode_stage;

    logic        d_clk = 1'b0;
    logic        d_rst;
    logic [31:0] d_i_inst, d_i_pc;
    logic        d_i_valid, d_i_stall, d_i_flush;
    logic        d_o_stall, d_o_valid;
    logic [31:0] d_o_pc, d_o_imm;
    logic [4:0]  d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd;
    logic [2:0]  d_o_funct3;
    logic [13:0] d_o_alu;
    logic [10:0] d_o_opcode;
    logic [3:0]  d_o_exception;

    always #5 d_clk = ~d_clk;

    decode_stage #(.AWIDTH(5), .DWIDTH(32), .PC_WIDTH(32)) dut (
        .d_clk(d_clk), .d_rst(d_rst), .d_i_inst(d_i_inst), .d_i_pc(d_i_pc),
        .d_i_valid(d_i_valid), .d_i_stall(d_i_stall), .d_i_flush(d_i_flush),
        .d_o_stall(d_o_stall), .d_o_valid(d_o_valid), .d_o_pc(d_o_pc),
        .d_o_addr_rs1(d_o_addr_rs1), .d_o_addr_rs2(d_o_addr_rs2),
        .d_o_addr_rd(d_o_addr_rd), .d_o_funct3(d_o_funct3), .d_o_imm(d_o_imm),
        .d_o_alu(d_o_alu), .d_o_opcode(d_o_opcode), .d_o_exception(d_o_exception)
    );

    localparam logic [13:0] A_ADD = 14'h0001, A_SUB = 14'h0002, A_SRA = 14'h0080,
                            A_EQ  = 14'h0400, A_0   = 14'h0000;
    localparam logic [10:0] O_R = 11'h001, O_I = 11'h002, O_LD = 11'h004, O_ST = 11'h008,
                            O_BR = 11'h010, O_JAL = 11'h020, O_LUI = 11'h080,
                            O_SYS = 11'h200, O_0 = 11'h000;
    localparam logic [3:0]  E_ILL = 4'h1, E_ECALL = 4'h2, E_EBREAK = 4'h4, E_MRET = 4'h8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
    } out_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        valid, stall, flush, exp_stall, hold;
        out_t        exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    out_t exp_q[$];
    out_t last_exp;
    vec_t tbl[$];

    function automatic out_t mk(input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                                input logic [2:0] f3, input logic [31:0] imm,
                                input logic [13:0] alu, input logic [10:0] opc,
                                input logic [3:0] exc);
        out_t o;
        o = '{valid: 1'b1, pc: pc, rs1: rs1, rs2: rs2, rd: rd, f3: f3, imm: imm,
              alu: alu, opc: opc, exc: exc};
        return o;
    endfunction

    function automatic vec_t mv(input logic [31:0] inst, pc, input logic valid, stall,
                                flush, exp_stall, hold, input out_t exp);
        vec_t v;
        v = '{inst: inst, pc: pc, valid: valid, stall: stall, flush: flush,
              exp_stall: exp_stall, hold: hold, exp: exp};
        return v;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o = '{valid: d_o_valid, pc: d_o_pc, rs1: d_o_addr_rs1, rs2: d_o_addr_rs2,
              rd: d_o_addr_rd, f3: d_o_funct3, imm: d_o_imm, alu: d_o_alu,
              opc: d_o_opcode, exc: d_o_exception};
        return o;
    endfunction

    task automatic check_out(input string name);
        out_t e, g;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            g = dut_out();
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", name, g, e);
            end
        end
    endtask

    task automatic check_stall(input string name, input logic e);
        checks++;
        if (d_o_stall !== e) begin
            errors++;
            $display("FAIL %s stall: got %b expected %b", name, d_o_stall, e);
        end
    endtask

    // Drive one cycle from a negedge, check the stall, then the registered result.
    task automatic run(input vec_t v, input string name);
        out_t e;
        d_i_inst  = v.inst;
        d_i_pc    = v.pc;
        d_i_valid = v.valid;
        d_i_stall = v.stall;
        d_i_flush = v.flush;
        #1;
        check_stall(name, v.exp_stall);
        e = v.hold ? last_exp : v.exp;
        exp_q.push_back(e);
        last_exp = e;
        @(posedge d_clk);
        #1;
        check_out(name);
        @(negedge d_clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        out_t bub;
        bub      = '0;
        last_exp = '0;

        tbl.push_back(mv(32'h002081B3, 32'h100, 1, 0, 0, 0, 0, mk(32'h100, 1, 2, 3, 0, 0, A_ADD, O_R, 0)));
        tbl.push_back(mv(32'h402081B3, 32'h104, 1, 0, 0, 0, 0, mk(32'h104, 1, 2, 3, 0, 0, A_SUB, O_R, 0)));
        tbl.push_back(mv(32'hFFF00293, 32'h108, 1, 0, 0, 0, 0, mk(32'h108, 0, 31, 5, 0, 32'hFFFFFFFF, A_ADD, O_I, 0)));
        tbl.push_back(mv(32'hFE208CE3, 32'h10C, 1, 0, 0, 0, 0, mk(32'h10C, 1, 2, 25, 0, 32'hFFFFFFF8, A_EQ, O_BR, 0)));
        tbl.push_back(mv(32'h00000073, 32'h110, 1, 0, 0, 0, 0, mk(32'h110, 0, 0, 0, 0, 0, A_0, O_SYS, E_ECALL)));
        tbl.push_back(mv(32'h00100073, 32'h114, 1, 0, 0, 0, 0, mk(32'h114, 0, 1, 0, 0, 0, A_0, O_SYS, E_EBREAK)));
        tbl.push_back(mv(32'h30200073, 32'h118, 1, 0, 0, 0, 0, mk(32'h118, 0, 2, 0, 0, 0, A_0, O_SYS, E_MRET)));
        tbl.push_back(mv(32'hFFFFFFFF, 32'h11C, 1, 0, 0, 0, 0, mk(32'h11C, 31, 31, 31, 7, 0, A_0, O_0, E_ILL)));
        tbl.push_back(mv(32'h123453B7, 32'h120, 1, 0, 0, 0, 0, mk(32'h120, 8, 3, 7, 5, 32'h12345000, A_ADD, O_LUI, 0)));
        tbl.push_back(mv(32'h0020A423, 32'h124, 1, 0, 0, 0, 0, mk(32'h124, 1, 2, 8, 2, 8, A_ADD, O_ST, 0)));
        tbl.push_back(mv(32'hFFDFF0EF, 32'h128, 1, 0, 0, 0, 0, mk(32'h128, 31, 29, 1, 7, 32'hFFFFFFFC, A_ADD, O_JAL, 0)));
        tbl.push_back(mv(32'h0020A063, 32'h12C, 1, 0, 0, 0, 0, mk(32'h12C, 1, 2, 0, 2, 0, A_0, O_BR, E_ILL)));
        tbl.push_back(mv(32'h4010D093, 32'h130, 1, 0, 0, 0, 0, mk(32'h130, 1, 1, 1, 5, 32'h401, A_SRA, O_I, 0)));
        tbl.push_back(mv(32'h0000B283, 32'h134, 1, 0, 0, 0, 0, mk(32'h134, 1, 0, 5, 3, 0, A_ADD, O_LD, E_ILL)));
        tbl.push_back(mv(32'h002081B3, 32'h138, 0, 0, 0, 0, 0, bub));

        // Reset state; downstream stall must not leak out while in reset.
        d_rst = 1'b0; d_i_inst = 32'h002081B3; d_i_pc = 32'h40; d_i_valid = 1'b1;
        d_i_stall = 1'b1; d_i_flush = 1'b0;
        #2;
        exp_q.push_back(bub);
        check_out("reset_state");
        check_stall("reset_state", 1'b0);
        d_i_stall = 1'b0;
        @(negedge d_clk);
        @(negedge d_clk);
        d_rst = 1'b1;

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Load-use through rs1: one stall cycle, one bubble, then the consumer.
        run(mv(32'h0000A283, 32'h200, 1, 0, 0, 0, 0, mk(32'h200, 1, 0, 5, 2, 0, A_ADD, O_LD, 0)), "lu_load");
        run(mv(32'h00028333, 32'h204, 1, 0, 0, 1, 0, bub), "lu_bubble");
        run(mv(32'h00028333, 32'h204, 1, 0, 0, 0, 0, mk(32'h204, 5, 0, 6, 0, 0, A_ADD, O_R, 0)), "lu_consumer");
        // Load-use through rs2.
        run(mv(32'h0000A283, 32'h208, 1, 0, 0, 0, 0, mk(32'h208, 1, 0, 5, 2, 0, A_ADD, O_LD, 0)), "lu2_load");
        run(mv(32'h00500333, 32'h20C, 1, 0, 0, 1, 0, bub), "lu2_bubble");
        run(mv(32'h00500333, 32'h20C, 1, 0, 0, 0, 0, mk(32'h20C, 0, 5, 6, 0, 0, A_ADD, O_R, 0)), "lu2_consumer");
        // Load to x0 never stalls.
        run(mv(32'h0000A003, 32'h210, 1, 0, 0, 0, 0, mk(32'h210, 1, 0, 0, 2, 0, A_ADD, O_LD, 0)), "x0_load");
        run(mv(32'h00000333, 32'h214, 1, 0, 0, 0, 0, mk(32'h214, 0, 0, 6, 0, 0, A_ADD, O_R, 0)), "x0_use");

        // Downstream stall holds the register for three cycles.
        run(mv(32'hFFF00293, 32'h300, 1, 0, 0, 0, 0, mk(32'h300, 0, 31, 5, 0, 32'hFFFFFFFF, A_ADD, O_I, 0)), "hold_base");
        for (int k = 0; k < 3; k++)
            run(mv(32'h402081B3, 32'h304, 1, 1, 0, 1, 1, bub), $sformatf("hold%0d", k));
        run(mv(32'h402081B3, 32'h304, 1, 0, 0, 0, 0, mk(32'h304, 1, 2, 3, 0, 0, A_SUB, O_R, 0)), "hold_release");
        // Flush beats stall.
        run(mv(32'h002081B3, 32'h308, 1, 1, 1, 1, 0, bub), "flush_stall");
        // Flush during a load-use hazard: no stall to fetch, bubble captured.
        run(mv(32'h0000A283, 32'h30C, 1, 0, 0, 0, 0, mk(32'h30C, 1, 0, 5, 2, 0, A_ADD, O_LD, 0)), "fh_load");
        run(mv(32'h00028333, 32'h310, 1, 0, 1, 0, 0, bub), "fh_flush");
        run(mv(32'h00028333, 32'h400, 1, 0, 0, 0, 0, mk(32'h400, 5, 0, 6, 0, 0, A_ADD, O_R, 0)), "fh_after");

        // Asynchronous reset mid-stream, held across an edge, then normal decode.
        d_i_inst = 32'hFFF00293; d_i_pc = 32'h500; d_i_valid = 1'b1;
        d_i_stall = 1'b0; d_i_flush = 1'b0;
        #2 d_rst = 1'b0;
        #1;
        exp_q.push_back(bub);
        check_out("async_reset");
        check_stall("async_reset", 1'b0);
        @(posedge d_clk);
        #1;
        exp_q.push_back(bub);
        check_out("reset_held");
        @(negedge d_clk);
        d_rst = 1'b1;
        last_exp = bub;
        run(mv(32'hFFF00293, 32'h500, 1, 0, 0, 0, 0, mk(32'h500, 0, 31, 5, 0, 32'hFFFFFFFF, A_ADD, O_I, 0)), "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
